pcileech_com_tx_arbiter: RTL and testbench

- Frame-level arbiter that shares the single host-bound COM TX word path (towards the FT601 buffered communication device) between three requesters: TLP, CFG and CORE status.
- Sits between the per-source packetizers inside the FIFO controller and the COM TX FIFO write port.
- Grants one requester at a time and holds the grant for a whole frame, so the words of one frame are never interleaved with another source.
- Emits each word with a 2-bit source tag.

---
 rtl/pcileech_com_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_pcileech_com_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_com_tx_arbiter.sv
// Frame-level arbiter that merges TLP/CFG/CORE word streams onto the single COM TX path, tagging each word with its source.
// Optional build macro PCILEECH_TXARB_FIXED_PRIO_EN selects fixed priority CFG > CORE > TLP instead of round-robin.
module pcileech_com_tx_arbiter #(
    parameter int PARAM_MAX_BURST = 64,
    parameter int PARAM_NUM_SRC   = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [PARAM_NUM_SRC-1:0][31:0]  src_data,
    input  logic [PARAM_NUM_SRC-1:0]        src_valid,
    input  logic [PARAM_NUM_SRC-1:0]        src_last,
    output logic [PARAM_NUM_SRC-1:0]        src_ready,
    output logic [31:0]                     dout,
    output logic [1:0]                      dout_tag,
    output logic                            dout_last,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic                            grant_busy,
    output logic [15:0]                     cnt_forced
);

    // Valid/ready: a beat moves on a rising edge where valid and ready are both high;
    // valid never waits on ready, and ready may depend combinationally on the downstream ready.

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [7:0] BEAT_LAST = 8'(PARAM_MAX_BURST - 1);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0] dout_q, dout_d;
    logic [1:0]  dout_tag_q, dout_tag_d;
    logic        dout_last_q, dout_last_d;
    logic        dout_valid_q, dout_valid_d;
    logic [15:0] cnt_forced_q, cnt_forced_d;

    logic        beat;
    logic        hit_max;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

`ifdef PCILEECH_TXARB_FIXED_PRIO_EN
    function automatic logic [1:0] pick_src(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] unused_last;
        unused_last = last;
        if (req[1])      return 2'd1;
        else if (req[2]) return 2'd2;
        else             return 2'd0;
    endfunction
`else
    // Search starts one past the previous winner so every requester is served within three frames.
    function automatic logic [1:0] pick_src(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] c;
        logic [1:0] pick;
        logic       found;
        c     = last;
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c = next_idx(c);
            if (!found && req[c]) begin
                pick  = c;
                found = 1'b1;
            end
        end
        return pick;
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        dout_d       = dout_q;
        dout_tag_d   = dout_tag_q;
        dout_last_d  = dout_last_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        cnt_forced_d = cnt_forced_q;
        src_ready    = '0;
        beat         = 1'b0;
        hit_max      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|src_valid) begin
                    grant_d    = pick_src(src_valid, last_grant_q);
                    beat_cnt_d = 8'd0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                src_ready[grant_q] = !dout_valid_q || dout_ready;
                beat               = src_valid[grant_q] && src_ready[grant_q];
                hit_max            = (beat_cnt_q == BEAT_LAST);
                if (beat) begin
                    dout_d       = src_data[grant_q];
                    dout_tag_d   = grant_q;
                    dout_last_d  = src_last[grant_q] || hit_max;
                    dout_valid_d = 1'b1;
                    beat_cnt_d   = beat_cnt_q + 8'd1;
                    if (src_last[grant_q] || hit_max) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                    // A forced cut leaves the rest of the frame for the source's next grant.
                    if (hit_max && !src_last[grant_q] && (cnt_forced_q != 16'hFFFF)) begin
                        cnt_forced_d = cnt_forced_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
            beat_cnt_q   <= 8'd0;
            dout_q       <= 32'd0;
            dout_tag_q   <= 2'd0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            cnt_forced_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            dout_q       <= dout_d;
            dout_tag_q   <= dout_tag_d;
            dout_last_q  <= dout_last_d;
            dout_valid_q <= dout_valid_d;
            cnt_forced_q <= cnt_forced_d;
        end
    end

    assign dout       = dout_q;
    assign dout_tag   = dout_tag_q;
    assign dout_last  = dout_last_q;
    assign dout_valid = dout_valid_q;
    assign grant_busy = (state_q == LOCK);
    assign cnt_forced = cnt_forced_q;

endmodule

// File: tb/tb_pcileech_com_tx_arbiter.sv
// Scoreboard bench for pcileech_com_tx_arbiter: expected {tag,last,data} words are queued as frames are driven.
module tb_pcileech_com_tx_arbiter;
    localparam int MAXB = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0][31:0] src_data;
    logic [2:0]       src_valid;
    logic [2:0]       src_last;
    logic [2:0]       src_ready;
    logic [31:0]      dout;
    logic [1:0]       dout_tag;
    logic             dout_last;
    logic             dout_valid;
    logic             dout_ready;
    logic             grant_busy;
    logic [15:0]      cnt_forced;

    logic [31:0] d_data[3];
    logic        d_valid[3];
    logic        d_last[3];

    logic [34:0] exp_q[$];
    int          beat_cyc[$];
    bit          sb_en = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    pcileech_com_tx_arbiter #(.PARAM_MAX_BURST(MAXB), .PARAM_NUM_SRC(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
        .dout(dout), .dout_tag(dout_tag), .dout_last(dout_last), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .grant_busy(grant_busy), .cnt_forced(cnt_forced)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            src_data[i]  = d_data[i];
            src_valid[i] = d_valid[i];
            src_last[i]  = d_last[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_valid[i] = 1'b0;
            d_last[i]  = 1'b0;
            d_data[i]  = 32'd0;
        end
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        sb_en = 1'b1;
    endtask

    // scoreboard model: word k of an n-word frame ends a grant at the real end or at every burst boundary
    task automatic push_words(input int s, input int n, input logic [31:0] base, input logic [31:0] step,
                              input int k0, input int k1);
        logic last;
        for (int k = k0; k <= k1; k++) begin
            last = (k == n - 1) || ((k % MAXB) == MAXB - 1);
            exp_q.push_back({2'(s), last, base + step * 32'(k)});
        end
    endtask

    // driver: present words of one frame, holding each until accepted
    task automatic send_frame(input int s, input int n, input logic [31:0] base, input logic [31:0] step,
                              input int pre);
        int budget;
        repeat (pre) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < n; k++) begin
            d_data[s]  = base + step * 32'(k);
            d_last[s]  = (k == n - 1);
            d_valid[s] = 1'b1;
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!src_ready[s] && budget < 3000);
            if (!src_ready[s]) begin
                chk($sformatf("src%0d_accept_timeout", s), 64'(budget), 64'd0);
                d_valid[s] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        d_valid[s] = 1'b0;
        d_last[s]  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard compare: a word is taken on the edge after this negedge
    always @(negedge clk) begin
        if (rst_n && sb_en && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("beat", {29'd0, dout_tag, dout_last, dout}, {29'd0, exp_q.pop_front()});
                beat_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int c0;
        bit found;
        int budget;

        dout_ready = 1'b1;
        do_reset();

        // reset state
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_tag", 64'(dout_tag), 64'd0);
        chk("rst_last", 64'(dout_last), 64'd0);
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_busy", 64'(grant_busy), 64'd0);
        chk("rst_cnt_forced", 64'(cnt_forced), 64'd0);

        // TLP 3-word frame, latency and back-to-back output
        beat_cyc.delete();
        push_words(0, 3, 32'h11, 32'h11, 0, 2);
        c0 = cyc;
        send_frame(0, 3, 32'h11, 32'h11, 0);
        wait_drain("t1_drain");
        chk("t1_beat_count", 64'(beat_cyc.size()), 64'd3);
        if (beat_cyc.size() >= 3) begin
            chk("t1_first_latency", 64'(beat_cyc[0] - c0), 64'd2);
            chk("t1_spacing", 64'(beat_cyc[2] - beat_cyc[0]), 64'd2);
        end
        chk("t1_busy_after", 64'(grant_busy), 64'd0);

        // all three sources, two single-word frames each
        do_reset();
`ifdef PCILEECH_TXARB_FIXED_PRIO_EN
        push_words(1, 1, 32'hA10, 1, 0, 0);
        push_words(1, 1, 32'hA11, 1, 0, 0);
        push_words(2, 1, 32'hA20, 1, 0, 0);
        push_words(2, 1, 32'hA21, 1, 0, 0);
        push_words(0, 1, 32'hA00, 1, 0, 0);
        push_words(0, 1, 32'hA01, 1, 0, 0);
`else
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) begin
                push_words(s, 1, 32'hA00 + 32'(s * 16 + r), 1, 0, 0);
            end
        end
`endif
        fork
            begin send_frame(0, 1, 32'hA00, 1, 0); send_frame(0, 1, 32'hA01, 1, 0); end
            begin send_frame(1, 1, 32'hA10, 1, 0); send_frame(1, 1, 32'hA11, 1, 0); end
            begin send_frame(2, 1, 32'hA20, 1, 0); send_frame(2, 1, 32'hA21, 1, 0); end
        join
        wait_drain("t2_drain");

        // CFG 70-word frame cut at the burst limit, others served in between
        do_reset();
`ifdef PCILEECH_TXARB_FIXED_PRIO_EN
        push_words(1, 70, 32'h1000, 1, 0, 69);
        push_words(2, 1, 32'hE00, 1, 0, 0);
        push_words(0, 1, 32'hF00, 1, 0, 0);
`else
        push_words(1, 70, 32'h1000, 1, 0, 63);
        push_words(2, 1, 32'hE00, 1, 0, 0);
        push_words(0, 1, 32'hF00, 1, 0, 0);
        push_words(1, 70, 32'h1000, 1, 64, 69);
`endif
        fork
            send_frame(1, 70, 32'h1000, 1, 0);
            send_frame(2, 1, 32'hE00, 1, 10);
            send_frame(0, 1, 32'hF00, 1, 10);
        join
        wait_drain("t3_drain");
        chk("t3_cnt_forced", 64'(cnt_forced), 64'd1);

        // downstream stall after word 2 of a TLP frame
        do_reset();
        push_words(0, 5, 32'hB00, 1, 0, 4);
        fork
            send_frame(0, 5, 32'hB00, 1, 0);
            begin
                found = 1'b0;
                budget = 0;
                while (!found && budget < 200) begin
                    @(posedge clk);
                    #1;
                    budget++;
                    if (dout_valid && dout == 32'hB01) found = 1'b1;
                end
                chk("t4_stall_sync", 64'(found), 64'd1);
                if (found) begin
                    dout_ready = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        @(negedge clk);
                        chk("t4_hold_dout", 64'(dout), 64'hB01);
                        chk("t4_hold_valid", 64'(dout_valid), 64'd1);
                        chk("t4_src_ready", 64'(src_ready), 64'd0);
                        chk("t4_busy", 64'(grant_busy), 64'd1);
                        @(posedge clk);
                        #1;
                    end
                    dout_ready = 1'b1;
                end
            end
        join
        wait_drain("t4_drain");

        // asynchronous reset in the middle of a frame
        do_reset();
        sb_en = 1'b0;
        d_data[0]  = 32'hC00;
        d_last[0]  = 1'b0;
        d_valid[0] = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        chk("t5_pre_valid", 64'(dout_valid), 64'd1);
        chk("t5_pre_ready", 64'(src_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(dout_valid), 64'd0);
        chk("t5_rst_ready", 64'(src_ready), 64'd0);
        chk("t5_rst_busy", 64'(grant_busy), 64'd0);
        chk("t5_rst_dout", 64'(dout), 64'd0);
        d_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb_en = 1'b1;
        push_words(2, 2, 32'hD00, 1, 0, 1);
        send_frame(2, 2, 32'hD00, 1, 0);
        wait_drain("t5_drain");

        // forced-release counter saturation
        do_reset();
        force dut.cnt_forced_q = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.cnt_forced_q;
        push_words(0, 3 * MAXB + 1, 32'h2000, 1, 0, 3 * MAXB);
        send_frame(0, 3 * MAXB + 1, 32'h2000, 1, 0);
        wait_drain("t6_drain");
        chk("t6_cnt_saturate", 64'(cnt_forced), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
